// File: rtl/servo_pwm_gen.sv
// Servo pulse generator: fixed-period PWM frame whose high time is the
// requested width clamped to [MIN_WIDTH, MAX_WIDTH] and latched once per frame.
module servo_pwm_gen #(
  parameter int unsigned PERIOD    = 2_000_000,
  parameter int unsigned MIN_WIDTH = 50_000,
  parameter int unsigned MAX_WIDTH = 250_000,
  parameter int unsigned CW        = 21
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          enable,
  input  logic [CW-1:0] to_pwm,
  output logic          pwm_out,
  output logic          done_period,
  output logic [CW-1:0] active_width,
  output logic          clamped,
  output logic          busy,
  output logic [15:0]   frame_count
);

  localparam int unsigned FCW = 16;

  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(PERIOD - 2);
  localparam logic [CW-1:0] W_MIN    = CW'(MIN_WIDTH);
  localparam logic [CW-1:0] W_MAX    = CW'(MAX_WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic             frame_start;

  logic [CW-1:0]    req_width;
  logic             req_out_of_range;

  logic             pwm_nx;
  logic             done_nx;
  logic [CW-1:0]    width_nx;
  logic             clamped_nx;
  logic             busy_nx;
  logic [FCW-1:0]   fcount_nx;

  // Clamp the live request to the safe pulse window (unsigned compare).
  always_comb begin
    req_width        = to_pwm;
    req_out_of_range = 1'b0;
    if (to_pwm < W_MIN) begin
      req_width        = W_MIN;
      req_out_of_range = 1'b1;
    end else if (to_pwm > W_MAX) begin
      req_width        = W_MAX;
      req_out_of_range = 1'b1;
    end
  end

  // Next state, frame counter and registered-output values.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    frame_start = 1'b0;
    width_nx    = active_width;
    clamped_nx  = clamped;
    fcount_nx   = frame_count;
    pwm_nx      = 1'b0;
    done_nx     = 1'b0;
    busy_nx     = 1'b0;

    unique case (state)
      IDLE: begin
        if (enable) begin
          state_nx    = RUN;
          cnt_nx      = '0;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          // Frame end: count it, then either chain the next frame or stop.
          fcount_nx = frame_count + FCW'(1);
          cnt_nx    = '0;
          if (enable) begin
            frame_start = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    // Width is only sampled on the edge that enters cnt = 0.
    if (frame_start) begin
      width_nx   = req_width;
      clamped_nx = req_out_of_range;
    end

    // Outputs are computed for the cycle being entered so they register cleanly.
    if (state_nx == RUN) begin
      busy_nx = 1'b1;
      pwm_nx  = (cnt_nx < width_nx);
      done_nx = (cnt_nx == CNT_DONE);
    end
  end

  // State, counter and output registers; reset aborts any frame in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      cnt          <= '0;
      pwm_out      <= 1'b0;
      done_period  <= 1'b0;
      active_width <= '0;
      clamped      <= 1'b0;
      busy         <= 1'b0;
      frame_count  <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      pwm_out      <= pwm_nx;
      done_period  <= done_nx;
      active_width <= width_nx;
      clamped      <= clamped_nx;
      busy         <= busy_nx;
      frame_count  <= fcount_nx;
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen: directed scenarios plus random traffic, checked
// every cycle against a frame-position model and per-frame high-time counts.
module tb_servo_pwm_gen;

  localparam int unsigned P    = 100;
  localparam int unsigned MINW = 5;
  localparam int unsigned MAXW = 25;
  localparam int unsigned CW   = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] to_pwm = '0;
  logic          pwm_out;
  logic          done_period;
  logic [CW-1:0] active_width;
  logic          clamped;
  logic          busy;
  logic [15:0]   frame_count;

  servo_pwm_gen #(
    .PERIOD(P), .MIN_WIDTH(MINW), .MAX_WIDTH(MAXW), .CW(CW)
  ) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .to_pwm(to_pwm),
    .pwm_out(pwm_out), .done_period(done_period), .active_width(active_width),
    .clamped(clamped), .busy(busy), .frame_count(frame_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: whether a frame is running, position in it, latched width, frames done.
  bit m_run;
  int m_pos;
  int m_w;
  bit m_clamped;
  int m_frames;
  int hi_obs;

  function automatic int clamp_w(input int r);
    if (r < int'(MINW)) return int'(MINW);
    if (r > int'(MAXW)) return int'(MAXW);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_w = 0; m_clamped = 0; m_frames = 0; hi_obs = 0;
  endtask

  task automatic start_frame();
    m_run     = 1;
    m_pos     = 0;
    m_w       = clamp_w(int'(to_pwm));
    m_clamped = (int'(to_pwm) < int'(MINW)) || (int'(to_pwm) > int'(MAXW));
  endtask

  task automatic model_edge();
    if (!m_run) begin
      if (enable) start_frame();
    end else if (m_pos == int'(P) - 1) begin
      check("frame_high_cycles", 32'(hi_obs), 32'(m_w));
      hi_obs = 0;
      m_frames++;
      if (enable) start_frame();
      else begin
        m_run = 0;
        m_pos = 0;
      end
    end else begin
      m_pos++;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pwm_out"},      32'(pwm_out),      32'(m_run && (m_pos < m_w)));
    check({tag, ".done_period"},  32'(done_period),  32'(m_run && (m_pos == int'(P) - 2)));
    check({tag, ".active_width"}, 32'(active_width), 32'(m_w));
    check({tag, ".clamped"},      32'(clamped),      32'(m_clamped));
    check({tag, ".busy"},         32'(busy),         32'(m_run));
    check({tag, ".frame_count"},  32'(frame_count),  32'(m_frames % 65536));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge CLK);
    if (RST) model_reset();
    else model_edge();
    #1;
    check_outputs("cycle");
    if (m_run && pwm_out === 1'b1) hi_obs++;
  endtask

  // Step until the model reaches frame position p (at least one step).
  task automatic run_until_pos(input int p);
    for (int n = 0; n < 300; n++) begin
      step();
      if (m_run && m_pos == p) return;
    end
    check("timeout_waiting_pos", 32'(m_pos), 32'(p));
  endtask

  initial begin
    model_reset();

    // Reset sweep: asynchronous assertion, held 3 cycles, released with enable=1.
    enable = 1'b1;
    to_pwm = 8'd10;
    #2 RST = 1'b1;
    #1;
    check_outputs("reset_async");
    repeat (3) step();
    RST = 1'b0;
    step();
    check("first_frame.busy", 32'(busy), 32'd1);
    check("first_frame.pwm_out", 32'(pwm_out), 32'd1);

    // Nominal frame: width 10, done at position 98, count increments at wrap.
    run_until_pos(98);
    check("nominal.done_period", 32'(done_period), 32'd1);
    check("nominal.active_width", 32'(active_width), 32'd10);
    check("nominal.clamped", 32'(clamped), 32'd0);
    step();
    check("nominal.done_single", 32'(done_period), 32'd0);
    step();
    check("nominal.frame_count", 32'(frame_count), 32'd1);

    // Clamp cases latched at successive frame starts.
    to_pwm = 8'd2;
    run_until_pos(0);
    check("clamp_low.width", 32'(active_width), 32'd5);
    check("clamp_low.clamped", 32'(clamped), 32'd1);
    to_pwm = 8'd40;
    run_until_pos(0);
    check("clamp_high.width", 32'(active_width), 32'd25);
    check("clamp_high.clamped", 32'(clamped), 32'd1);
    to_pwm = 8'd25;
    run_until_pos(0);
    check("clamp_edge.width", 32'(active_width), 32'd25);
    check("clamp_edge.clamped", 32'(clamped), 32'd0);
    to_pwm = 8'd10;
    run_until_pos(0);

    // Mid-frame change only takes effect at the next frame.
    run_until_pos(50);
    to_pwm = 8'd20;
    run_until_pos(99);
    check("midchange.current_width", 32'(active_width), 32'd10);
    step();
    check("midchange.next_width", 32'(active_width), 32'd20);

    // Graceful stop: frame completes, then idle with pwm low.
    run_until_pos(30);
    enable = 1'b0;
    run_until_pos(98);
    check("stop.done_period", 32'(done_period), 32'd1);
    step();
    step();
    check("stop.busy", 32'(busy), 32'd0);
    check("stop.pwm_out", 32'(pwm_out), 32'd0);
    repeat (5) step();
    check("stop.idle_pwm", 32'(pwm_out), 32'd0);
    enable = 1'b1;
    step();

    // Drop and re-assert before the frame end: back-to-back frames.
    run_until_pos(30);
    enable = 1'b0;
    run_until_pos(70);
    enable = 1'b1;
    run_until_pos(99);
    step();
    check("reassert.busy", 32'(busy), 32'd1);
    check("reassert.pwm_out", 32'(pwm_out), 32'd1);

    // Closed loop: controller adds one to the width on every done strobe.
    to_pwm = 8'd10;
    run_until_pos(0);
    check("loop.width0", 32'(active_width), 32'd10);
    for (int k = 1; k <= 5; k++) begin
      for (int n = 0; n < int'(P); n++) begin
        step();
        if (m_run && m_pos == int'(P) - 2) to_pwm = to_pwm + 8'd1;
      end
      check("loop.width", 32'(active_width), 32'(10 + k));
    end

    // Random traffic: request changes anywhere, enable toggling.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) to_pwm = 8'($urandom_range(0, 255));
      if (r == 50) enable = ~enable;
      step();
    end

    // Reset mid-pulse: pwm drops immediately and the counter clears.
    enable = 1'b1;
    to_pwm = 8'd20;
    run_until_pos(0);
    run_until_pos(0);
    run_until_pos(7);
    check("rst_mid.pwm_before", 32'(pwm_out), 32'd1);
    #2 RST = 1'b1;
    #1;
    model_reset();
    check("rst_mid.pwm_out", 32'(pwm_out), 32'd0);
    check("rst_mid.frame_count", 32'(frame_count), 32'd0);
    check_outputs("rst_mid");
    step();
    enable = 1'b0;
    RST = 1'b0;
    repeat (4) step();
    check("rst_mid.stays_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
